// File: rtl/gpu_pkg.sv
// gpu_pkg: shared vertex/colour/triangle-word types and frame sequencer state encoding.
package gpu_pkg;
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] z;
    logic [31:0] y;
    logic [31:0] x;
  } vertex_t;
  typedef logic [11:0] color_t;
  typedef struct packed {
    color_t  color;
    vertex_t v;
  } tri_word_t;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, SEND, DRAIN, SWAP, SETTLE} seq_state_t;
endpackage

// File: rtl/seq_stats.sv
// seq_stats: frame duration and overrun-tick counters for frame_sequencer, both saturating.
module seq_stats (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_swap,
  input  logic        i_tick,
  input  logic        i_pending,
  output logic [23:0] o_frame_cycles,
  output logic [15:0] o_overrun_count
);
  logic [23:0] r_run;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run           <= '0;
      o_frame_cycles  <= '0;
      o_overrun_count <= '0;
    end else begin
      r_run <= i_start ? 24'd1 : (&r_run ? r_run : r_run + 24'd1);
      if (i_swap) o_frame_cycles <= r_run;
      if (i_tick && i_pending && !(&o_overrun_count)) o_overrun_count <= o_overrun_count + 16'd1;
    end
  end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: fetches 3 vertex words per triangle from triangle RAM, streams them to the
// rasterizer, then swaps/clears the framebuffer. SEQ_STATS_EN adds frame-cycle/overrun counters.
module frame_sequencer
  import gpu_pkg::*;
#(
  parameter  int MAX_TRIS    = 256,
  parameter  int MEM_LATENCY = 2,
  parameter  int DRAIN_MIN   = 4,
  localparam int ADDR_W      = $clog2(3 * MAX_TRIS)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_tick_in,
  input  logic [15:0]       num_tris_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [139:0]      mem_data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [127:0]      vertex_out,
  output logic [11:0]       color_out,
  input  logic              raster_idle_in,
  input  logic              framebuffer_ready_in,
  output logic              fb_switch_out,
  output logic              fb_clear_out,
  output logic              busy_out,
  output logic [15:0]       frame_count_out
`ifdef SEQ_STATS_EN
  ,
  output logic [23:0]       frame_cycles_out,
  output logic [15:0]       overrun_count_out
`endif
);
  seq_state_t        r_state;
  logic              r_pending;
  logic              r_seen_low;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_last;
  logic [1:0]        r_phase;
  logic [7:0]        r_cnt;
  tri_word_t         w_word;
  logic [15:0]       w_n;
  logic              w_start;
  assign w_word          = mem_data_in;
  assign w_n             = num_tris_in > 16'(MAX_TRIS) ? 16'(MAX_TRIS) : num_tris_in;
  assign w_start         = r_state == IDLE && r_pending && framebuffer_ready_in;
  assign valid_out       = r_state == SEND;
  assign fb_switch_out   = r_state == SWAP;
  assign fb_clear_out    = r_state == SWAP;
  assign busy_out        = r_state != IDLE;
  assign mem_addr_out    = r_idx;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state         <= IDLE;
      r_pending       <= 1'b0;
      r_seen_low      <= 1'b0;
      r_idx           <= '0;
      r_last          <= '0;
      r_phase         <= '0;
      r_cnt           <= '0;
      vertex_out      <= '0;
      color_out       <= '0;
      frame_count_out <= '0;
    end else begin
      r_pending <= frame_tick_in | (r_pending & ~w_start);
      case (r_state)
        IDLE: if (w_start) begin
          r_idx   <= '0;
          r_phase <= '0;
          r_last  <= ADDR_W'(18'(w_n) * 18'd3 - 18'd1);
          r_state <= w_n == 16'd0 ? SWAP : FETCH;
        end
        FETCH: begin
          r_cnt   <= '0;
          r_state <= WAIT_MEM;
        end
        WAIT_MEM: if (r_cnt == 8'(MEM_LATENCY - 1)) begin
          vertex_out <= w_word.v;
          if (r_phase == 2'd0) color_out <= w_word.color;
          r_state <= SEND;
        end else r_cnt <= r_cnt + 8'd1;
        // the address stays on the last word once the frame's final vertex is taken
        SEND: if (ready_in) begin
          r_cnt   <= '0;
          r_phase <= r_phase == 2'd2 ? 2'd0 : r_phase + 2'd1;
          if (r_idx == r_last) r_state <= DRAIN;
          else begin
            r_idx   <= r_idx + ADDR_W'(1);
            r_state <= FETCH;
          end
        end
        DRAIN: if (r_cnt < 8'(DRAIN_MIN)) r_cnt <= r_cnt + 8'd1;
          else if (raster_idle_in && framebuffer_ready_in) r_state <= SWAP;
        SWAP: begin
          frame_count_out <= frame_count_out + 16'd1;
          r_cnt           <= '0;
          r_seen_low      <= 1'b0;
          r_state         <= SETTLE;
        end
        // a clear may finish too fast to see ready drop, so 8 high cycles also count as done
        SETTLE: if (!framebuffer_ready_in) begin
          r_seen_low <= 1'b1;
          r_cnt      <= '0;
        end else if (r_seen_low || r_cnt == 8'd7) r_state <= IDLE;
          else r_cnt <= r_cnt + 8'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef SEQ_STATS_EN
  seq_stats u_stats (
    .i_clk          (clk_in),
    .i_rst          (rst_in),
    .i_start        (w_start),
    .i_swap         (r_state == SWAP),
    .i_tick         (frame_tick_in),
    .i_pending      (r_pending),
    .o_frame_cycles (frame_cycles_out),
    .o_overrun_count(overrun_count_out)
  );
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized self-checking bench with a triangle RAM, framebuffer and rasterizer model.
module tb_frame_sequencer;
  localparam int L    = 2;
  localparam int MAXT = 256;
  logic         clk = 1'b0;
  logic         rst_in, frame_tick_in, ready_in, raster_idle_in, framebuffer_ready_in;
  logic [15:0]  num_tris_in;
  logic [9:0]   mem_addr_out;
  logic [139:0] mem_data_in;
  logic         valid_out, fb_switch_out, fb_clear_out, busy_out;
  logic [127:0] vertex_out;
  logic [11:0]  color_out;
  logic [15:0]  frame_count_out;
`ifdef SEQ_STATS_EN
  logic [23:0]  frame_cycles_out;
  logic [15:0]  overrun_count_out;
`endif
  always #5 clk = ~clk;

  frame_sequencer dut (
    .clk_in(clk), .rst_in(rst_in), .frame_tick_in(frame_tick_in), .num_tris_in(num_tris_in),
    .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in), .valid_out(valid_out),
    .ready_in(ready_in), .vertex_out(vertex_out), .color_out(color_out),
    .raster_idle_in(raster_idle_in), .framebuffer_ready_in(framebuffer_ready_in),
    .fb_switch_out(fb_switch_out), .fb_clear_out(fb_clear_out), .busy_out(busy_out),
    .frame_count_out(frame_count_out)
`ifdef SEQ_STATS_EN
    , .frame_cycles_out(frame_cycles_out), .overrun_count_out(overrun_count_out)
`endif
  );

  // sync-read triangle RAM with a two-cycle address-to-data latency
  logic [139:0] ram [768];
  logic [139:0] d1, d2;
  always @(posedge clk) begin
    d1 <= ram[int'(mem_addr_out)];
    d2 <= d1;
  end
  assign mem_data_in = d2;

  typedef struct packed {logic [127:0] v; logic [11:0] c; logic [9:0] a;} acc_t;
  acc_t acc_q[$];
  int errors = 0, checks = 0, exp_frames = 0, bad_k = 0;
  int first_busy, first_valid, pulses, first_pulse, last_acc, rise_cyc, bad_stable, bad_pair, timed_out;

  task automatic fill_ram();
    for (int a = 0; a < 768; a++)
      ram[a] = {12'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'(a)};
  endtask

  // expected stream: word k of a frame is RAM[k mod 3n], colour from the triangle's first word
  function automatic int seq_errors(input int per);
    int e = 0;
    for (int k = 0; k < acc_q.size(); k++) begin
      int a = k % per;
      if (acc_q[k].a !== 10'(a) || acc_q[k].v !== ram[a][127:0] || acc_q[k].c !== ram[a - a % 3][139:128]) begin
        if (e == 0) bad_k = k;
        e++;
      end
    end
    return e;
  endfunction

  task automatic run_frame(input int ntris, input int rdy_pct, input int idle_hold, input int tick_at, input bit scramble);
    int cyc = 0, quiet = 0, fb_low = 0, idle_cnt = 0, per;
    logic hold = 1'b0;
    logic [127:0] hv = '0;
    logic [11:0] hc = '0;
    per = 3 * (ntris > MAXT ? MAXT : ntris);
    acc_q.delete();
    first_busy = -1; first_valid = -1; pulses = 0; first_pulse = -1; last_acc = -1;
    rise_cyc = -1; bad_stable = 0; bad_pair = 0; timed_out = 0;
    @(negedge clk);
    num_tris_in = 16'(ntris);
    frame_tick_in = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      frame_tick_in = tick_at > 0 && (cyc == tick_at || cyc == tick_at + 3);
      if (scramble && cyc >= 3) num_tris_in = 16'($urandom);
      if (busy_out && first_busy < 0) first_busy = cyc;
      if (valid_out && first_valid < 0) first_valid = cyc;
      if (hold && (!valid_out || vertex_out !== hv || color_out !== hc)) bad_stable++;
      if (fb_switch_out !== fb_clear_out) bad_pair++;
      if (fb_switch_out) begin
        pulses++;
        if (first_pulse < 0) first_pulse = cyc;
        fb_low = $urandom_range(0, 3);
      end
      framebuffer_ready_in = fb_low == 0;
      if (fb_low > 0) fb_low--;
      if (idle_cnt > 0) begin
        idle_cnt--;
        if (idle_cnt == 0) begin
          raster_idle_in = 1'b1;
          rise_cyc = cyc;
        end
      end
      ready_in = $urandom_range(0, 99) < rdy_pct;
      if (valid_out && ready_in) begin
        acc_q.push_back('{v: vertex_out, c: color_out, a: mem_addr_out});
        last_acc = cyc;
        if (idle_hold > 0 && acc_q.size() == per) begin
          raster_idle_in = 1'b0;
          idle_cnt = idle_hold;
        end
      end
      hold = valid_out && !ready_in;
      hv = vertex_out;
      hc = color_out;
      quiet = busy_out ? 0 : quiet + 1;
      if (cyc > 3 && quiet >= 12) break;
      if (cyc >= 20000) begin
        timed_out = 1;
        break;
      end
    end
    ready_in = 1'b0; framebuffer_ready_in = 1'b1; raster_idle_in = 1'b1; frame_tick_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; frame_tick_in = 1'b0; ready_in = 1'b0; num_tris_in = '0;
    raster_idle_in = 1'b1; framebuffer_ready_in = 1'b1;
    fill_ram();
    repeat (3) @(negedge clk);
    checks++; if ({valid_out, busy_out, fb_switch_out, fb_clear_out} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {valid_out, busy_out, fb_switch_out, fb_clear_out});
    end
    checks++; if (frame_count_out !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", frame_count_out);
    end
    checks++; if ({mem_addr_out, vertex_out, color_out} !== '0) begin
      errors++; $display("FAIL reset_data: addr %0d vertex %h color %h, want all 0", mem_addr_out, vertex_out, color_out);
    end
`ifdef SEQ_STATS_EN
    checks++; if ({frame_cycles_out, overrun_count_out} !== '0) begin
      errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", frame_cycles_out, overrun_count_out);
    end
`endif
    rst_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy_out !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy %b want 0", busy_out);
    end
  endtask

  task automatic test_reset_mid_send();
    int seen = 0, vcnt = 0, pcnt = 0;
    num_tris_in = 16'd3;
    ready_in = 1'b0;
    @(negedge clk); frame_tick_in = 1'b1;
    @(negedge clk); frame_tick_in = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (valid_out) seen = 1;
    end
    checks++; if (seen !== 1) begin
      errors++; $display("FAIL rst_send_reach: valid seen %0d want 1", seen);
    end
    rst_in = 1'b1;
    @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin
      errors++; $display("FAIL rst_send_valid: got %b want 0", valid_out);
    end
    rst_in = 1'b0; ready_in = 1'b1;
    repeat (30) begin
      @(negedge clk);
      vcnt += int'(valid_out);
      pcnt += int'(fb_switch_out | fb_clear_out);
    end
    ready_in = 1'b0;
    exp_frames = 0;
    checks++; if (vcnt !== 0 || pcnt !== 0) begin
      errors++; $display("FAIL rst_send_quiet: valid %0d pulses %0d want 0/0", vcnt, pcnt);
    end
    checks++; if (frame_count_out !== 16'(exp_frames)) begin
      errors++; $display("FAIL rst_send_count: got %0d want %0d", frame_count_out, exp_frames);
    end
  endtask

  task automatic test_single_tri();
    ram[0] = {12'hFFF, 32'h3F800000, 32'h0, 32'h42200000, 32'h43200000};
    ram[1] = {12'h123, 32'h3F800000, 32'h0, 32'h42A00000, 32'h42C80000};
    ram[2] = {12'h456, 32'h3F800000, 32'h0, 32'h42C80000, 32'h43480000};
    run_frame(1, 100, 0, 0, 0);
    exp_frames++;
    checks++; if (timed_out !== 0 || acc_q.size() !== 3) begin
      errors++; $display("FAIL single_accepts: got %0d timeout %0d want 3", acc_q.size(), timed_out);
    end
    checks++; if (seq_errors(3) !== 0) begin
      errors++; $display("FAIL single_seq: %0d bad words, first at %0d addr %0d", seq_errors(3), bad_k, acc_q[bad_k].a);
    end
    checks++; if (acc_q.size() == 3 && acc_q[2].c !== 12'hFFF) begin
      errors++; $display("FAIL single_color: got %h want fff", acc_q[2].c);
    end
    checks++; if (first_valid - first_busy !== 1 + L) begin
      errors++; $display("FAIL single_latency: busy->valid %0d want %0d", first_valid - first_busy, 1 + L);
    end
    checks++; if (pulses !== 1 || bad_pair !== 0) begin
      errors++; $display("FAIL single_pulse: pulses %0d unpaired %0d want 1/0", pulses, bad_pair);
    end
    checks++; if (frame_count_out !== 16'(exp_frames)) begin
      errors++; $display("FAIL single_count: got %0d want %0d", frame_count_out, exp_frames);
    end
  endtask

  task automatic test_random_ready();
    fill_ram();
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(2, 5);
      run_frame(n, 30, 0, 0, 1);
      exp_frames++;
      checks++; if (timed_out !== 0 || acc_q.size() !== 3 * n) begin
        errors++; $display("FAIL rand_accepts: got %0d timeout %0d want %0d", acc_q.size(), timed_out, 3 * n);
      end
      checks++; if (seq_errors(3 * n) !== 0) begin
        errors++; $display("FAIL rand_seq: %0d bad words, first at %0d", seq_errors(3 * n), bad_k);
      end
      checks++; if (bad_stable !== 0) begin
        errors++; $display("FAIL rand_stable: %0d unstable stall cycles want 0", bad_stable);
      end
      checks++; if (pulses !== 1 || frame_count_out !== 16'(exp_frames)) begin
        errors++; $display("FAIL rand_frame: pulses %0d count %0d want 1/%0d", pulses, frame_count_out, exp_frames);
      end
    end
  endtask

  task automatic test_zero_tris();
    run_frame(0, 100, 0, 0, 0);
    exp_frames++;
    checks++; if (first_valid !== -1) begin
      errors++; $display("FAIL zero_valid: valid at cycle %0d want none", first_valid);
    end
    checks++; if (first_pulse < 1 || first_pulse > 3 || pulses !== 1) begin
      errors++; $display("FAIL zero_pulse: first at %0d count %0d want 1..3/1", first_pulse, pulses);
    end
    checks++; if (frame_count_out !== 16'(exp_frames)) begin
      errors++; $display("FAIL zero_count: got %0d want %0d", frame_count_out, exp_frames);
    end
`ifdef SEQ_STATS_EN
    checks++; if (frame_cycles_out !== 24'd1) begin
      errors++; $display("FAIL zero_cycles: got %0d want 1", frame_cycles_out);
    end
`endif
  endtask

  task automatic test_drain_hold();
    fill_ram();
    run_frame(2, 100, 100, 0, 0);
    exp_frames++;
    checks++; if (rise_cyc < 0 || first_pulse !== rise_cyc + 1) begin
      errors++; $display("FAIL drain_pulse: pulse at %0d want %0d", first_pulse, rise_cyc + 1);
    end
    checks++; if (first_pulse - last_acc <= 100) begin
      errors++; $display("FAIL drain_wait: accept->pulse %0d want >100", first_pulse - last_acc);
    end
    checks++; if (pulses !== 1 || frame_count_out !== 16'(exp_frames)) begin
      errors++; $display("FAIL drain_frame: pulses %0d count %0d want 1/%0d", pulses, frame_count_out, exp_frames);
    end
  endtask

  task automatic test_overrun();
    run_frame(2, 100, 0, 6, 0);
    exp_frames += 2;
    checks++; if (acc_q.size() !== 12 || seq_errors(6) !== 0) begin
      errors++; $display("FAIL overrun_accepts: got %0d bad %0d want 12/0", acc_q.size(), seq_errors(6));
    end
    checks++; if (pulses !== 2 || frame_count_out !== 16'(exp_frames)) begin
      errors++; $display("FAIL overrun_frames: pulses %0d count %0d want 2/%0d", pulses, frame_count_out, exp_frames);
    end
`ifdef SEQ_STATS_EN
    checks++; if (overrun_count_out !== 16'd1) begin
      errors++; $display("FAIL overrun_stat: got %0d want 1", overrun_count_out);
    end
`endif
  endtask

  task automatic test_max_tris();
    fill_ram();
    run_frame(1000, 100, 0, 0, 0);
    exp_frames++;
    checks++; if (timed_out !== 0 || acc_q.size() !== 768) begin
      errors++; $display("FAIL max_accepts: got %0d timeout %0d want 768", acc_q.size(), timed_out);
    end
    checks++; if (acc_q.size() > 0 && acc_q[acc_q.size() - 1].a !== 10'd767) begin
      errors++; $display("FAIL max_last_addr: got %0d want 767", acc_q[acc_q.size() - 1].a);
    end
    checks++; if (seq_errors(768) !== 0) begin
      errors++; $display("FAIL max_seq: %0d bad words, first at %0d", seq_errors(768), bad_k);
    end
    checks++; if (frame_count_out !== 16'(exp_frames)) begin
      errors++; $display("FAIL max_count: got %0d want %0d", frame_count_out, exp_frames);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_send();
    test_single_tri();
    test_random_ready();
    test_zero_tris();
    test_drain_hold();
    test_overrun();
    test_max_tris();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
